key_display_ctrl: RTL and testbench
===================================

KEY_DISPLAY_CTRL -- requirements
Module: key_display_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: data  input  8  keyboard scan-code byte offered by the upstream receiver.
REQ-004 SHALL have port: valid  input  1  data holds a new byte.
REQ-005 SHALL have port: ready  output  1  controller can accept a byte this cycle.
REQ-006 SHALL have port: code_h  output  4  high nibble of the displayed key code; feeds the hex-digit decoder.
REQ-007 SHALL have port: code_l  output  4  low nibble of the displayed key code.
REQ-008 SHALL have port: code_en  output  1  digit-enable for the key-code pair; 0 blanks both digits.
REQ-009 SHALL have port: cnt_h  output  4  BCD tens of the key-press count.
REQ-010 SHALL have port: cnt_l  output  4  BCD units of the key-press count.
REQ-011 SHALL have port: cnt_en  output  1  digit-enable for the count pair.

Function
REQ-012 SHALL accept a byte only in a cycle where valid=1 and ready=1; valid with ready=0 is ignored, with no effect on state.
REQ-013 SHALL drive ready from a register, forcing it to 0 for exactly the one cycle after an accept and to 1 otherwise, giving at most one byte per 2 cycles.
REQ-014 SHALL register all outputs; effects of a byte accepted in cycle N SHALL be visible from cycle N+1.
REQ-015 SHALL implement FSM states IDLE (no key held), HELD (key held, code shown) and BRK (F0 received).
REQ-016 SHALL ignore byte 8'hE0 in every state: no state, output or count change.
REQ-017 IDLE: on byte F0 SHALL go to BRK; on any other non-E0 byte SHALL latch it into code_h/code_l, set code_en=1, increment the count and go to HELD.
REQ-018 HELD: a byte equal to the latched code (typematic repeat) SHALL cause no change; F0 SHALL go to BRK; any other non-E0 byte SHALL latch the new code, increment the count and stay in HELD.
REQ-019 BRK: a byte equal to the latched code while code_en=1 SHALL clear code_en and go to IDLE, leaving code_h/code_l unchanged.
REQ-020 BRK: any other byte, including F0, SHALL be discarded, with no count change; the FSM SHALL return to HELD if code_en=1, otherwise to IDLE.
REQ-021 SHALL keep the count as two BCD digits, 00-99; an increment from 99 SHALL wrap to 00; an increment from x9 SHALL carry into the tens digit.
REQ-022 SHALL set cnt_en to 1 on the first counted press and hold it at 1 until reset, including across a wrap to 00.
REQ-023 SHALL never produce a BCD digit value above 9 on cnt_h or cnt_l.

Reset
REQ-024 rst=1 at a clock edge SHALL force: state IDLE, code_h=0, code_l=0, code_en=0, cnt_h=0, cnt_l=0, cnt_en=0, ready=1.
REQ-025 Reset SHALL take priority over a simultaneous accept; a byte offered during reset SHALL be dropped.
REQ-026 Reset asserted mid-sequence (in BRK or HELD) SHALL discard the pending break context; the next byte SHALL be treated as in IDLE.

Structure
REQ-027 The shared package SHALL hold the FSM state enum (IDLE, HELD, BRK) and the constants BREAK_CODE=8'hF0 and EXT_CODE=8'hE0.
REQ-028 The count SHALL be a sub-module bcd_cnt2 with inputs clk, rst and inc and outputs tens and ones, wrapping 99->00.
REQ-029 Outputs code_h/code_l/code_en and cnt_h/cnt_l/cnt_en SHALL connect directly to two instances of the existing two-digit hex decoder (h, l, flag).

Verification
REQ-030 Reset, then offer 1C with valid held -> ready pattern 1,0,1; code=1C; code_en=1; count=01; cnt_en=1.
REQ-031 From IDLE, send 1C, 1C, 1C, F0, 1C -> count stays 01; after the final 1C code_en=0 and code stays 1C.
REQ-032 Send 1C, then 32, then F0, 32 -> 32 displayed after the second byte; count=02; release of 32 blanks the display.
REQ-033 Send 100 distinct make/break pairs -> count walks 09->10 and 99->00; cnt_en stays 1; no digit exceeds 9.
REQ-034 Send E0, 75 -> code=75 and count=01; then F0, 2A -> discarded, code_en stays 1 with code 75.
REQ-035 Send 1C, F0, then assert rst for one cycle, then send 1C -> all outputs zero after reset; the next 1C is counted as a new press, count=01.

Source files
------------

// File: rtl/key_display_ctrl_pkg.sv
// Shared definitions for the keyboard scan-code display controller.
package key_display_ctrl_pkg;

    // Controller states: no key held, key held with code shown, break prefix seen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        BRK  = 2'd2
    } kd_state_t;

    // Scan-code prefixes: F0 announces a key release, E0 an extended key.
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    // Digit width of the BCD count.
    localparam int BCD_W = 4;

endpackage

// File: rtl/key_display_ctrl_bcd_cnt2.sv
// Two-digit BCD key-press counter, 00..99, wraps back to 00.
module bcd_cnt2
    import key_display_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    // Units roll over into tens at 9; tens roll over to 0 at 99.
    always_ff @(posedge clk) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones == 4'd9) begin
                ones <= '0;
                if (tens == 4'd9) begin
                    tens <= '0;
                end else begin
                    tens <= tens + 4'd1;
                end
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/key_display_ctrl.sv
// Keyboard scan-code display controller: shows the held key code and counts
// key presses. Handshake: a byte transfers on a rising edge where valid=1 and
// ready=1; ready is registered and drops for exactly one cycle after every
// transfer, so at most one byte is taken every two cycles. valid while
// ready=0 is ignored and leaves every register untouched.
module key_display_ctrl
    import key_display_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic [3:0] code_h,
    output logic [3:0] code_l,
    output logic       code_en,
    output logic [3:0] cnt_h,
    output logic [3:0] cnt_l,
    output logic       cnt_en
);

    // Current state is kept visible by name (state) for external checkers.
    kd_state_t  state;
    kd_state_t  state_d;
    logic [7:0] code_q;
    logic [7:0] code_d;
    logic       code_en_q;
    logic       code_en_d;
    logic       ready_q;
    logic       cnt_en_q;
    logic       inc;
    logic       accept;

    assign accept  = valid & ready_q;
    assign ready   = ready_q;
    assign code_h  = code_q[7:4];
    assign code_l  = code_q[3:0];
    assign code_en = code_en_q;
    assign cnt_en  = cnt_en_q;

    // Handshake throttle: one dead cycle after each accepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ~accept;
        end
    end

    // State, displayed code and enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            code_q    <= '0;
            code_en_q <= 1'b0;
        end else begin
            state     <= state_d;
            code_q    <= code_d;
            code_en_q <= code_en_d;
        end
    end

    // Count enable latches on the first counted press and stays on until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_en_q <= 1'b0;
        end else if (inc) begin
            cnt_en_q <= 1'b1;
        end
    end

    // Next-state decode; E0 is transparent in every state.
    always_comb begin
        state_d   = state;
        code_d    = code_q;
        code_en_d = code_en_q;
        inc       = 1'b0;
        if (accept && data != EXT_CODE) begin
            case (state)
                IDLE: begin
                    if (data == BREAK_CODE) begin
                        state_d = BRK;
                    end else begin
                        code_d    = data;
                        code_en_d = 1'b1;
                        inc       = 1'b1;
                        state_d   = HELD;
                    end
                end
                HELD: begin
                    if (data == code_q) begin
                        state_d = HELD;   // typematic repeat of the held key
                    end else if (data == BREAK_CODE) begin
                        state_d = BRK;
                    end else begin
                        code_d    = data;
                        code_en_d = 1'b1;
                        inc       = 1'b1;
                        state_d   = HELD;
                    end
                end
                BRK: begin
                    if (data == code_q && code_en_q) begin
                        code_en_d = 1'b0;  // release of the shown key blanks it
                        state_d   = IDLE;
                    end else begin
                        state_d = code_en_q ? HELD : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    bcd_cnt2 u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc),
        .tens (cnt_h),
        .ones (cnt_l)
    );

endmodule

// File: tb/tb_key_display_ctrl.sv
// Directed bench for key_display_ctrl.
module tb_key_display_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [3:0] code_h;
    logic [3:0] code_l;
    logic       code_en;
    logic [3:0] cnt_h;
    logic [3:0] cnt_l;
    logic       cnt_en;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] exp_q[$];

    key_display_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .data    (data),
        .valid   (valid),
        .ready   (ready),
        .code_h  (code_h),
        .code_l  (code_l),
        .code_en (code_en),
        .cnt_h   (cnt_h),
        .cnt_l   (cnt_l),
        .cnt_en  (cnt_en)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one-cycle synchronous reset
    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // offer one byte, wait (bounded) for ready, transfer it, drop valid
    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        while (ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            chk("ready_timeout", 32'd0, 32'd1);
        end else begin
            data  = b;
            valid = 1'b1;
            @(posedge clk);
            #1;
            valid = 1'b0;
        end
    endtask

    task automatic chk_disp(input string tag, input logic [7:0] c, input logic en,
                            input logic [7:0] cnt, input logic cen);
        chk({tag, "_code"},   {code_h, code_l}, c);
        chk({tag, "_codeen"}, code_en, en);
        chk({tag, "_cnt"},    {cnt_h, cnt_l}, cnt);
        chk({tag, "_cnten"},  cnt_en, cen);
    endtask

    initial begin
        int n;
        logic [7:0] e;
        logic [7:0] k;
        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_ready", ready, 1'b1);
        chk_disp("rst", 8'h00, 1'b0, 8'h00, 1'b0);

        // 1C held on valid across the dead cycle: ready 1,0,1 and one press
        data  = 8'h1C;
        valid = 1'b1;
        chk("hs_ready0", ready, 1'b1);
        @(negedge clk);
        chk("hs_ready1", ready, 1'b0);
        @(negedge clk);
        chk("hs_ready2", ready, 1'b1);
        valid = 1'b0;
        chk_disp("hs", 8'h1C, 1'b1, 8'h01, 1'b1);

        // typematic repeats then release
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        chk_disp("rep", 8'h1C, 1'b1, 8'h01, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk_disp("rel", 8'h1C, 1'b0, 8'h01, 1'b1);
        send_byte(8'h1C);
        chk_disp("repress", 8'h1C, 1'b1, 8'h02, 1'b1);

        // second key replaces first; E0 inside break is transparent
        do_reset();
        send_byte(8'h1C);
        send_byte(8'h32);
        chk_disp("k2", 8'h32, 1'b1, 8'h02, 1'b1);
        send_byte(8'hF0);
        send_byte(8'hE0);
        send_byte(8'h32);
        chk_disp("k2rel", 8'h32, 1'b0, 8'h02, 1'b1);

        // extended prefix ignored; stray break discarded back to HELD
        do_reset();
        send_byte(8'hE0);
        chk_disp("e0", 8'h00, 1'b0, 8'h00, 1'b0);
        send_byte(8'h75);
        chk_disp("ext", 8'h75, 1'b1, 8'h01, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h2A);
        chk_disp("stray", 8'h75, 1'b1, 8'h01, 1'b1);
        send_byte(8'h75);
        chk_disp("stray_rep", 8'h75, 1'b1, 8'h01, 1'b1);
        send_byte(8'hF0);
        send_byte(8'hF0);
        chk_disp("dblbrk", 8'h75, 1'b1, 8'h01, 1'b1);

        // reset drops a byte offered with it and discards break context
        do_reset();
        send_byte(8'h1C);
        send_byte(8'hF0);
        @(negedge clk);
        rst   = 1'b1;
        data  = 8'h1C;
        valid = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        chk("mid_ready", ready, 1'b1);
        chk_disp("mid", 8'h00, 1'b0, 8'h00, 1'b0);
        send_byte(8'h1C);
        chk_disp("post", 8'h1C, 1'b1, 8'h01, 1'b1);

        // 100 distinct make/break pairs: BCD walk with carries and 99->00 wrap
        do_reset();
        for (int i = 0; i < 100; i++) begin
            n = (i + 1) % 100;
            e = {4'(n / 10), 4'(n % 10)};
            exp_q.push_back(e);
        end
        for (int i = 0; i < 100; i++) begin
            k = 8'(i + 1);
            send_byte(k);
            e = exp_q.pop_front();
            chk("walk_cnt", {cnt_h, cnt_l}, e);
            chk("walk_h_le9", (cnt_h <= 4'd9), 1'b1);
            chk("walk_l_le9", (cnt_l <= 4'd9), 1'b1);
            send_byte(8'hF0);
            send_byte(k);
            chk("walk_rel", code_en, 1'b0);
        end
        chk("walk_end_cnt", {cnt_h, cnt_l}, 8'h00);
        chk("walk_end_cnten", cnt_en, 1'b1);
        chk("walk_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
